// File: rtl/load_fmap_ring_if.sv
// load_fmap_ring_if: multi-lane feature-map beat bus with valid/ready handshake
interface load_fmap_ring_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES = 2
);
    logic [LANES*DATA_WIDTH-1:0] fmap_in;
    logic fmap_in_valid;
    logic fmap_in_ready;
    modport master (output fmap_in, fmap_in_valid, input fmap_in_ready);
    modport slave (input fmap_in, fmap_in_valid, output fmap_in_ready);
endinterface

// File: rtl/load_fmap_ring.sv
// load_fmap_ring: beat FIFO unpacked word-by-word into a circular scratch pad
// with full-map and credit-released column load modes.
module load_fmap_ring #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES = 2,
    parameter int FIFO_DEPTH_W = 2,
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic rst,
    load_fmap_ring_if.slave bus,
    input  logic load_start,
    input  logic load_mode,
    input  logic [ADDR_W:0] load_len,
    input  logic [ADDR_W:0] ready_thresh,
    input  logic col_release,
    input  logic [ADDR_W:0] release_len,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_W-1:0] pixel_point,
    output logic busy,
    output logic pad_data_ready,
    output logic pad_full,
    output logic load_done,
    output logic fmap_ready_to_pe
);
    localparam int FD = 1 << FIFO_DEPTH_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [LANES-1:0][DATA_WIDTH-1:0] fifo_mem [FD];
    logic [DATA_WIDTH-1:0] pad [DEPTH];
    logic [FIFO_DEPTH_W:0] wptr, wptr_q, rptr;
    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0] occ, cnt, len, thresh, occ_w, rel;
    logic [LW-1:0] lane;
    logic [DATA_WIDTH-1:0] word;
    logic armed, fifo_empty, fifo_full, push, pop, we, last, start;
    // A pushed beat becomes visible one cycle later, giving the two-edge fill latency
    assign fifo_empty = rptr == wptr_q;
    assign fifo_full = wptr[FIFO_DEPTH_W] != rptr[FIFO_DEPTH_W] &&
                       wptr[FIFO_DEPTH_W-1:0] == rptr[FIFO_DEPTH_W-1:0];
    assign word = fifo_mem[rptr[FIFO_DEPTH_W-1:0]][lane];
    assign start = state == IDLE && load_start;
    assign we = !rst && state == RUN && !fifo_empty && !occ[ADDR_W];
    assign last = cnt + 1'b1 == len;
    assign pop = we && (lane == LW'(LANES - 1) || last);
    assign push = bus.fmap_in_valid && bus.fmap_in_ready;
    assign bus.fmap_in_ready = !fifo_full || pop;
    assign occ_w = occ + (ADDR_W+1)'(we);
    assign rel = !col_release ? '0 : release_len < occ_w ? release_len : occ_w;
    assign busy = state != IDLE;
    assign load_done = state == DONE;
    assign pad_full = occ[ADDR_W];
    assign pad_data_ready = armed && cnt >= thresh;
    always_comb begin
        state_n = state;
        if (start) state_n = load_len == '0 ? DONE : RUN;
        if (state == RUN && we && last) state_n = DONE;
        if (state == DONE) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            wptr_q <= '0;
            rptr <= '0;
            head <= '0;
            tail <= '0;
            occ <= '0;
            cnt <= '0;
            len <= '0;
            thresh <= '0;
            lane <= '0;
            armed <= 1'b0;
            pixel_point <= '0;
            fmap_ready_to_pe <= 1'b0;
        end else begin
            wptr_q <= wptr;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (start) begin
                len <= load_len;
                thresh <= ready_thresh;
                cnt <= '0;
                lane <= '0;
                armed <= 1'b1;
                fmap_ready_to_pe <= 1'b0;
                pixel_point <= load_mode ? head : '0;
                head <= load_mode ? head : '0;
                tail <= load_mode ? tail + rel[ADDR_W-1:0] : '0;
                occ <= load_mode ? occ_w - rel : '0;
            end else begin
                tail <= tail + rel[ADDR_W-1:0];
                occ <= occ_w - rel;
                if (we) begin
                    head <= head + 1'b1;
                    cnt <= cnt + 1'b1;
                    lane <= pop ? '0 : lane + 1'b1;
                end
                if (state == DONE) fmap_ready_to_pe <= 1'b1;
            end
        end
    end
    // Same-cycle read of the write address returns the old word
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else rdata <= pad[raddr];
    end
    always_ff @(posedge clk) if (we) pad[head] <= word;
    always_ff @(posedge clk) if (push) fifo_mem[wptr[FIFO_DEPTH_W-1:0]] <= bus.fmap_in;
endmodule

// File: tb/tb_load_fmap_ring.sv
// tb_load_fmap_ring: directed checks of full, column, wrap, back-pressure and reset loads
module tb_load_fmap_ring;
    localparam int AW = 4;
    logic clk = 0, rst = 1;
    logic load_start = 0, load_mode = 0, col_release = 0;
    logic [AW:0] load_len = '0, ready_thresh = '0, release_len = '0;
    logic [AW-1:0] raddr = '0;
    logic [15:0] rdata;
    logic [AW-1:0] pixel_point;
    logic busy, pad_data_ready, pad_full, load_done, fmap_ready_to_pe;
    load_fmap_ring_if #(.DATA_WIDTH(16), .LANES(2)) bus ();
    load_fmap_ring #(.DATA_WIDTH(16), .LANES(2), .FIFO_DEPTH_W(2), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .load_start(load_start), .load_mode(load_mode),
        .load_len(load_len), .ready_thresh(ready_thresh), .col_release(col_release),
        .release_len(release_len), .raddr(raddr), .rdata(rdata), .pixel_point(pixel_point),
        .busy(busy), .pad_data_ready(pad_data_ready), .pad_full(pad_full),
        .load_done(load_done), .fmap_ready_to_pe(fmap_ready_to_pe)
    );
    always #5 clk = ~clk;
    logic [31:0] q[$];
    int nxt = 1, nchk = 0, npass = 0, done_cnt = 0, d0, base;
    logic acc, saw_full;
    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (pad_full) saw_full = 1;
    end
    // Source model: present the queue head, retire it once the handshake completes
    initial begin
        bus.fmap_in_valid = 0;
        bus.fmap_in = '0;
        forever begin
            @(negedge clk);
            bus.fmap_in_valid = q.size() != 0;
            bus.fmap_in = q.size() != 0 ? q[0] : '0;
            #2 acc = bus.fmap_in_valid && bus.fmap_in_ready && !rst;
            @(posedge clk);
            if (acc) void'(q.pop_front());
        end
    end
    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back({16'(nxt + 1), 16'(nxt)});
            nxt += 2;
        end
    endtask
    task automatic start_load(input logic m, input int l, input int t);
        @(negedge clk);
        load_start = 1;
        load_mode = m;
        load_len = (AW+1)'(l);
        ready_thresh = (AW+1)'(t);
        @(negedge clk);
        load_start = 0;
        chk("busy_on_start", busy, 1);
        chk("frtp_cleared", fmap_ready_to_pe, 0);
    endtask
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask
    task automatic release_words(input int n);
        @(negedge clk);
        col_release = 1;
        release_len = (AW+1)'(n);
        @(negedge clk);
        col_release = 0;
    endtask
    task automatic rd(input int a, input int exp);
        @(negedge clk);
        raddr = AW'(a);
        @(negedge clk);
        chk($sformatf("rdata[%0d]", a), rdata, exp);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ready", bus.fmap_in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_pp", pixel_point, 0);
        chk("rst_full", pad_full, 0);
        chk("rst_pdr", pad_data_ready, 0);
        chk("rst_frtp", fmap_ready_to_pe, 0);
        chk("rst_rdata", rdata, 0);
        // full load of 7 words from 4 beats; word 8 is dropped
        push_beats(4);
        d0 = done_cnt;
        start_load(0, 7, 4);
        wait_idle("full_idle");
        chk("full_done_once", done_cnt - d0, 1);
        chk("full_frtp", fmap_ready_to_pe, 1);
        chk("full_pp", pixel_point, 0);
        chk("full_pdr", pad_data_ready, 1);
        for (int a = 0; a < 7; a++) rd(a, a + 1);
        push_beats(1);
        start_load(0, 2, 2);
        wait_idle("full2_idle");
        rd(0, 9);
        rd(1, 10);
        // zero-length column load: done pulse, no writes
        d0 = done_cnt;
        start_load(1, 0, 0);
        chk("len0_done", load_done, 1);
        wait_idle("len0_idle");
        chk("len0_done_once", done_cnt - d0, 1);
        chk("len0_pp", pixel_point, 2);
        chk("len0_frtp", fmap_ready_to_pe, 1);
        rd(2, 3);
        // column loads with release after each
        do_reset();
        saw_full = 0;
        push_beats(6);
        for (int k = 0; k < 3; k++) begin
            start_load(1, 4, 4);
            wait_idle("col_idle");
            chk("col_pp", pixel_point, 4 * k);
            release_words(4);
        end
        chk("col_never_full", saw_full, 0);
        rd(0, 11);
        rd(8, 19);
        rd(11, 22);
        // wrap-around from address 14
        push_beats(3);
        start_load(1, 2, 2);
        wait_idle("wrap_pre_idle");
        chk("wrap_pre_pp", pixel_point, 12);
        start_load(1, 4, 4);
        wait_idle("wrap_idle");
        chk("wrap_pp", pixel_point, 14);
        rd(14, 25);
        rd(15, 26);
        rd(0, 27);
        rd(1, 28);
        // over-release saturates occupancy so a full-depth load fits afterwards
        do_reset();
        push_beats(3);
        start_load(0, 5, 5);
        wait_idle("ovr_pre_idle");
        release_words(20);
        push_beats(8);
        start_load(1, 16, 16);
        wait_idle("ovr_idle");
        chk("ovr_pp", pixel_point, 5);
        chk("ovr_full", pad_full, 1);
        rd(5, 35);
        rd(4, 50);
        release_words(16);
        chk("ovr_unfull", pad_full, 0);
        // back-pressure: third 6-word load stalls on a full ring
        do_reset();
        base = nxt;
        push_beats(13);
        for (int k = 0; k < 2; k++) begin
            start_load(1, 6, 6);
            wait_idle("bp_idle");
            chk("bp_pp", pixel_point, 6 * k);
        end
        d0 = done_cnt;
        start_load(1, 6, 6);
        repeat (25) @(negedge clk);
        chk("bp_stall_busy", busy, 1);
        chk("bp_stall_full", pad_full, 1);
        chk("bp_fifo_full", bus.fmap_in_ready, 0);
        chk("bp_no_done", done_cnt - d0, 0);
        load_start = 1;
        load_mode = 0;
        load_len = 5'd3;
        @(negedge clk);
        load_start = 0;
        chk("busy_start_ignored_pp", pixel_point, 12);
        chk("busy_start_ignored_busy", busy, 1);
        release_words(6);
        wait_idle("bp_idle3");
        chk("bp_done_once", done_cnt - d0, 1);
        chk("bp_pp3", pixel_point, 12);
        rd(15, base + 15);
        rd(0, base + 16);
        rd(1, base + 17);
        start_load(0, 8, 0);
        wait_idle("drain_idle");
        rd(0, base + 18);
        rd(7, base + 25);
        // reset in the middle of a load
        push_beats(2);
        d0 = done_cnt;
        start_load(0, 8, 3);
        for (int i = 0; i < 50 && !pad_data_ready; i++) @(negedge clk);
        chk("mid_thresh", pad_data_ready, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_busy", busy, 0);
        chk("mid_pdr", pad_data_ready, 0);
        chk("mid_frtp", fmap_ready_to_pe, 0);
        chk("mid_pp", pixel_point, 0);
        chk("mid_ready", bus.fmap_in_ready, 1);
        chk("mid_rdata", rdata, 0);
        repeat (3) @(negedge clk);
        chk("mid_no_done", done_cnt - d0, 0);
        push_beats(1);
        start_load(0, 2, 2);
        wait_idle("post_idle");
        rd(0, 81);
        rd(1, 82);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
